awg_segment_sequencer: RTL and testbench
========================================

Name: awg_segment_sequencer

Overview:
- Table-driven scheduler that sequences one AWG waveform output channel through a programmed list of pulse segments.
- Each segment carries:
  - valid amplitude and zero amplitude;
  - data and zero durations;
  - a repeat count.
- It drives the channel's amplitude and duration inputs and issues one trigger per repetition, with cycle-exact spacing. It also issues a stop at the end of the sequence or on abort.
- It sits between the host configuration registers and the waveform output module.

Parameters:
- DEPTH, 16, number of segment table entries
- AW, 4, table address width (log2 DEPTH)
- AMP_W, 16, amplitude width
- DUR_W, 32, duration width
- REP_W, 16, repeat-count width

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-low reset
- cfg_we  in  1  table write strobe
- cfg_addr  in  AW  table write address
- cfg_amp  in  AMP_W  valid amplitude for the entry
- cfg_zamp  in  AMP_W  zero amplitude for the entry
- cfg_data_dur  in  DUR_W  data-phase cycles
- cfg_zero_dur  in  DUR_W  zero-phase cycles
- cfg_rep  in  REP_W  repetitions (0 is treated as 1)
- i_last_idx  in  AW  index of the final segment; sampled at start
- i_loop  in  1  wrap to segment 0 after the final segment; sampled at start
- i_start  in  1  start request (level)
- i_abort  in  1  abort request (level)
- o_valid_amp  out  AMP_W  registered amplitude to the channel
- o_zero_amp  out  AMP_W  registered zero amplitude
- o_data_duration  out  DUR_W  registered duration
- o_zero_duration  out  DUR_W  registered duration
- o_trigger  out  1  one-cycle trigger per repetition
- o_stop  out  1  one-cycle stop pulse
- o_busy  out  1  high in any non-IDLE state
- o_seg_idx  out  AW  current segment index
- o_done  out  1  one-cycle pulse on normal completion
- o_cfg_err  out  1  one-cycle pulse when a write is rejected

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; all counters 0. Table contents are not reset.
- Table writes:
  - Accepted only in IDLE; the entry is written on the clk edge while cfg_we=1.
  - cfg_we=1 outside IDLE: write dropped, o_cfg_err=1 on the next cycle.
- Period: P = data_dur + zero_dur, computed at DUR_W+1 bits with no wrap. P=0 is forced to 1.
- Internal registers:
  - timer, DUR_W+1 bits;
  - rep_cnt, REP_W bits;
  - idx, AW bits;
  - latched last_idx and loop.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - i_start=1 and i_abort=0 → LOAD.
  - Latch i_last_idx and i_loop; idx=0.
- LOAD (1 cycle):
  - Register table[idx] onto o_valid_amp, o_zero_amp, o_data_duration and o_zero_duration.
  - rep_cnt=0, timer=0, o_seg_idx=idx → RUN.
- RUN:
  - o_trigger=1 exactly when timer==0; timer increments each cycle.
  - At timer==P-1, evaluated in this order:
    - rep_cnt < rep-1: rep_cnt+1, timer=0, stay in RUN. Trigger spacing is exactly P.
    - else idx != last_idx: idx+1 → LOAD. Trigger spacing is P+1.
    - else loop=1: idx=0 → LOAD.
    - else → DONE.
- DONE (1 cycle): o_done=1, o_stop=1 → IDLE.
- Abort: i_abort=1 in LOAD, RUN or DONE → IDLE next cycle, with o_stop=1 on that transition and no o_done.
  - Abort has priority over every other transition, including the final period end.
  - i_abort=1 in IDLE has no effect.
- i_start while busy is ignored. i_start held high through DONE restarts immediately, because IDLE sees i_start=1 again.
- Amplitude and duration outputs hold their last loaded values after DONE or abort.
- o_trigger and o_stop are never high in the same cycle.
- A write in the same cycle as the start: the write is accepted (the state is IDLE) and is visible if its address is LOADed afterwards.
- i_last_idx > DEPTH-1 cannot occur, because of the width.

Test Plan:
- 1. Single segment: entry0 = {amp 0x1234, zamp 0, data 3, zero 2, rep 1}, last_idx 0, loop 0, start pulse.
  - o_trigger exactly once, 2 cycles after start.
  - o_valid_amp=0x1234 one cycle earlier.
  - o_done and o_stop pulse 5 cycles after the trigger; o_busy drops next.
- 2. Repeats and boundary: entry0 {data 2, zero 2, rep 3}, entry1 {data 1, zero 0, rep 2}, last_idx 1.
  - Trigger gaps 4, 4, 5, 1.
  - o_seg_idx goes 0→1.
  - Exactly one o_done.
- 3. Loop and abort: two entries with loop=1; run 3 full sequences, then raise i_abort mid-RUN.
  - Triggers continue across the wrap with a P+1 gap at index 1→0.
  - One o_stop after abort, no o_done, IDLE next cycle.
- 4. Zero and edge periods:
  - rep=0 and data=zero=0 give one trigger and a 1-cycle period.
  - data=0xFFFFFFFF, zero=1 gives P=2^32 computed without overflow; check the 33-bit compare by forcing timer.
- 5. Config guard: cfg_we while busy at addr 0 with amp 0xBEEF.
  - o_cfg_err pulses 1 cycle; table unchanged; the loop-restarted entry0 still shows the old amp.
- 6. Reset mid-RUN: deassert rst asynchronously.
  - All outputs go to 0 immediately and the state is IDLE.
  - After release, a start replays the retained table correctly.

Source files
------------

// File: rtl/awg_segment_sequencer.sv
// Segment-table scheduler for one AWG output channel: loads each segment's
// amplitudes/durations, fires one trigger per repetition, and stops at the end or on abort.
module awg_segment_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int AMP_W = 16,
  parameter int DUR_W = 32,
  parameter int REP_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [AMP_W-1:0] cfg_amp,
  input  logic [AMP_W-1:0] cfg_zamp,
  input  logic [DUR_W-1:0] cfg_data_dur,
  input  logic [DUR_W-1:0] cfg_zero_dur,
  input  logic [REP_W-1:0] cfg_rep,
  input  logic [AW-1:0]    i_last_idx,
  input  logic             i_loop,
  input  logic             i_start,
  input  logic             i_abort,
  output logic [AMP_W-1:0] o_valid_amp,
  output logic [AMP_W-1:0] o_zero_amp,
  output logic [DUR_W-1:0] o_data_duration,
  output logic [DUR_W-1:0] o_zero_duration,
  output logic             o_trigger,
  output logic             o_stop,
  output logic             o_busy,
  output logic [AW-1:0]    o_seg_idx,
  output logic             o_done,
  output logic             o_cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [DUR_W:0]     timer_q, timer_d;
  logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [AW-1:0]      last_idx_q, last_idx_d;
  logic               loop_q, loop_d;
  logic [AMP_W-1:0]   valid_amp_q, valid_amp_d;
  logic [AMP_W-1:0]   zero_amp_q, zero_amp_d;
  logic [DUR_W-1:0]   data_dur_q, data_dur_d;
  logic [DUR_W-1:0]   zero_dur_q, zero_dur_d;
  logic [AW-1:0]      seg_idx_q, seg_idx_d;
  logic               trigger_q, trigger_d;
  logic               stop_q, stop_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;

  logic [AMP_W-1:0]   tbl_amp  [DEPTH];
  logic [AMP_W-1:0]   tbl_zamp [DEPTH];
  logic [DUR_W-1:0]   tbl_data [DEPTH];
  logic [DUR_W-1:0]   tbl_zero [DEPTH];
  logic [REP_W-1:0]   tbl_rep  [DEPTH];

  logic [DUR_W:0]     period;
  logic [DUR_W:0]     period_last;
  logic [REP_W-1:0]   rep_last;

  // Table storage carries no reset so a programmed sequence survives rst.
  always_ff @(posedge clk) begin
    if (cfg_we && (state_q == S_IDLE)) begin
      tbl_amp[cfg_addr]  <= cfg_amp;
      tbl_zamp[cfg_addr] <= cfg_zamp;
      tbl_data[cfg_addr] <= cfg_data_dur;
      tbl_zero[cfg_addr] <= cfg_zero_dur;
      tbl_rep[cfg_addr]  <= cfg_rep;
    end
  end

  // One extra bit keeps data+zero from wrapping; an all-zero period runs as 1 cycle.
  always_comb begin
    period = {1'b0, data_dur_q} + {1'b0, zero_dur_q};
    if (period == '0) period = (DUR_W+1)'(1);
    period_last = period - (DUR_W+1)'(1);
    rep_last    = (rep_q == '0) ? '0 : rep_q - REP_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    rep_cnt_d   = rep_cnt_q;
    rep_d       = rep_q;
    idx_d       = idx_q;
    last_idx_d  = last_idx_q;
    loop_d      = loop_q;
    valid_amp_d = valid_amp_q;
    zero_amp_d  = zero_amp_q;
    data_dur_d  = data_dur_q;
    zero_dur_d  = zero_dur_q;
    seg_idx_d   = seg_idx_q;
    trigger_d   = 1'b0;
    stop_d      = 1'b0;
    done_d      = 1'b0;
    busy_d      = (state_q != S_IDLE);
    cfg_err_d   = cfg_we && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          state_d    = S_LOAD;
          last_idx_d = i_last_idx;
          loop_d     = i_loop;
          idx_d      = '0;
        end
      end
      S_LOAD: begin
        if (i_abort) begin
          state_d = S_IDLE;
          stop_d  = 1'b1;
        end else begin
          valid_amp_d = tbl_amp[idx_q];
          zero_amp_d  = tbl_zamp[idx_q];
          data_dur_d  = tbl_data[idx_q];
          zero_dur_d  = tbl_zero[idx_q];
          rep_d       = tbl_rep[idx_q];
          rep_cnt_d   = '0;
          timer_d     = '0;
          seg_idx_d   = idx_q;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          state_d = S_IDLE;
          stop_d  = 1'b1;
        end else begin
          trigger_d = (timer_q == '0);
          timer_d   = timer_q + (DUR_W+1)'(1);
          if (timer_q == period_last) begin
            if (rep_cnt_q < rep_last) begin
              rep_cnt_d = rep_cnt_q + REP_W'(1);
              timer_d   = '0;
            end else if (idx_q != last_idx_q) begin
              idx_d   = idx_q + AW'(1);
              state_d = S_LOAD;
            end else if (loop_q) begin
              idx_d   = '0;
              state_d = S_LOAD;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        stop_d  = 1'b1;
        done_d  = !i_abort;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      rep_cnt_q   <= '0;
      rep_q       <= '0;
      idx_q       <= '0;
      last_idx_q  <= '0;
      loop_q      <= 1'b0;
      valid_amp_q <= '0;
      zero_amp_q  <= '0;
      data_dur_q  <= '0;
      zero_dur_q  <= '0;
      seg_idx_q   <= '0;
      trigger_q   <= 1'b0;
      stop_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_q       <= rep_d;
      idx_q       <= idx_d;
      last_idx_q  <= last_idx_d;
      loop_q      <= loop_d;
      valid_amp_q <= valid_amp_d;
      zero_amp_q  <= zero_amp_d;
      data_dur_q  <= data_dur_d;
      zero_dur_q  <= zero_dur_d;
      seg_idx_q   <= seg_idx_d;
      trigger_q   <= trigger_d;
      stop_q      <= stop_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign o_valid_amp     = valid_amp_q;
  assign o_zero_amp      = zero_amp_q;
  assign o_data_duration = data_dur_q;
  assign o_zero_duration = zero_dur_q;
  assign o_trigger       = trigger_q;
  assign o_stop          = stop_q;
  assign o_busy          = busy_q;
  assign o_seg_idx       = seg_idx_q;
  assign o_done          = done_q;
  assign o_cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_awg_segment_sequencer.sv
// Directed bench for awg_segment_sequencer; timing is counted in negedges (k) after start is raised.
module tb_awg_segment_sequencer;
  localparam int AW = 4, AMP_W = 16, DUR_W = 32, REP_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cfg_we = 1'b0;
  logic [AW-1:0]    cfg_addr = '0;
  logic [AMP_W-1:0] cfg_amp = '0, cfg_zamp = '0;
  logic [DUR_W-1:0] cfg_data_dur = '0, cfg_zero_dur = '0;
  logic [REP_W-1:0] cfg_rep = '0;
  logic [AW-1:0]    i_last_idx = '0;
  logic             i_loop = 1'b0, i_start = 1'b0, i_abort = 1'b0;
  logic [AMP_W-1:0] o_valid_amp, o_zero_amp;
  logic [DUR_W-1:0] o_data_duration, o_zero_duration;
  logic             o_trigger, o_stop, o_busy, o_done, o_cfg_err;
  logic [AW-1:0]    o_seg_idx;

  int pass_cnt = 0;
  int total    = 0;

  int trig_k[$];
  int seg_k[$];
  int amp_k[$];
  int done_cnt, stop_cnt, done_k, stop_k, coinc, busy_low_k;

  awg_segment_sequencer #(.DEPTH(16), .AW(AW), .AMP_W(AMP_W), .DUR_W(DUR_W), .REP_W(REP_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_amp(cfg_amp),
    .cfg_zamp(cfg_zamp), .cfg_data_dur(cfg_data_dur), .cfg_zero_dur(cfg_zero_dur),
    .cfg_rep(cfg_rep), .i_last_idx(i_last_idx), .i_loop(i_loop), .i_start(i_start),
    .i_abort(i_abort), .o_valid_amp(o_valid_amp), .o_zero_amp(o_zero_amp),
    .o_data_duration(o_data_duration), .o_zero_duration(o_zero_duration),
    .o_trigger(o_trigger), .o_stop(o_stop), .o_busy(o_busy), .o_seg_idx(o_seg_idx),
    .o_done(o_done), .o_cfg_err(o_cfg_err)
  );

  always #5 clk = ~clk;

  task automatic wr(input int addr, input int amp, input int zamp,
                    input logic [31:0] data, input logic [31:0] zero, input int rep);
    cfg_addr = AW'(addr); cfg_amp = AMP_W'(amp); cfg_zamp = AMP_W'(zamp);
    cfg_data_dur = data; cfg_zero_dur = zero; cfg_rep = REP_W'(rep);
    cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic start_seq(input int last, input logic loop_en);
    i_last_idx = AW'(last);
    i_loop     = loop_en;
    i_start    = 1'b1;
  endtask

  // Records what happens over n negedges; start drops after the first edge.
  task automatic capture(input int n, input int abort_k);
    trig_k.delete(); seg_k.delete(); amp_k.delete();
    done_cnt = 0; stop_cnt = 0; done_k = -1; stop_k = -1; coinc = 0; busy_low_k = -1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) i_start = 1'b0;
      if (o_trigger) trig_k.push_back(k);
      seg_k.push_back(int'(o_seg_idx));
      amp_k.push_back(int'(o_valid_amp));
      if (o_done) begin done_cnt++; done_k = k; end
      if (o_stop) begin stop_cnt++; stop_k = k; end
      if (o_trigger && o_stop) coinc++;
      if (!o_busy && busy_low_k < 0 && k > 1) busy_low_k = k;
      if (k == abort_k) i_abort = 1'b1;
    end
    i_abort = 1'b0;
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    else pass_cnt++;
  endtask

  task automatic check_trigs(input string name, input int exp_t[$]);
    int got;
    check_int({name, "_count"}, trig_k.size(), exp_t.size());
    for (int i = 0; i < exp_t.size(); i++) begin
      got = (i < trig_k.size()) ? trig_k[i] : -1;
      check_int($sformatf("%s_trig%0d", name, i), got, exp_t[i]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({o_valid_amp, o_zero_amp, o_data_duration, o_zero_duration, o_trigger, o_stop,
         o_busy, o_seg_idx, o_done, o_cfg_err} !== '0) $display("FAIL reset_outputs: not all zero");
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle_abort();
    i_abort = 1'b1; i_start = 1'b1;
    repeat (3) @(negedge clk);
    check_int("idle_abort_busy", int'(o_busy), 0);
    i_abort = 1'b0; i_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    wr(0, 'h1234, 0, 3, 2, 1);
    start_seq(0, 1'b0);
    capture(12, 0);
    check_int("single_amp_k1", amp_k[0], 0);
    check_int("single_amp_k2", amp_k[1], 'h1234);
    check_trigs("single", '{3});
    check_int("single_done_k", done_k, 8);
    check_int("single_stop_k", stop_k, 8);
    check_int("single_done_cnt", done_cnt, 1);
    check_int("single_busy_low_k", busy_low_k, 9);
  endtask

  task automatic test_repeats();
    wr(0, 'h0A0A, 1, 2, 2, 3);
    wr(1, 'h0B0B, 2, 1, 0, 2);
    start_seq(1, 1'b0);
    capture(25, 0);
    check_trigs("repeats", '{3, 7, 11, 16, 17});
    check_int("repeats_seg_k3", seg_k[2], 0);
    check_int("repeats_seg_k14", seg_k[13], 0);
    check_int("repeats_seg_k16", seg_k[15], 1);
    check_int("repeats_amp_k16", amp_k[15], 'h0B0B);
    check_int("repeats_done_cnt", done_cnt, 1);
    check_int("repeats_done_k", done_k, 18);
    check_int("repeats_coinc", coinc, 0);
  endtask

  task automatic test_loop_abort();
    wr(0, 'h1111, 0, 1, 1, 1);
    wr(1, 'h2222, 0, 2, 1, 1);
    start_seq(1, 1'b1);
    capture(30, 24);
    check_trigs("loop", '{3, 6, 10, 13, 17, 20, 24});
    check_int("loop_done_cnt", done_cnt, 0);
    check_int("loop_stop_cnt", stop_cnt, 1);
    check_int("loop_stop_k", stop_k, 25);
    check_int("loop_busy_low_k", busy_low_k, 26);
    check_int("loop_coinc", coinc, 0);
  endtask

  task automatic test_zero_period();
    wr(0, 'h0C0C, 0, 0, 0, 0);
    start_seq(0, 1'b0);
    capture(8, 0);
    check_trigs("zero", '{3});
    check_int("zero_done_k", done_k, 4);
  endtask

  task automatic test_wide_period();
    wr(0, 'h0D0D, 0, 32'hFFFF_FFFF, 1, 1);
    start_seq(0, 1'b0);
    @(negedge clk); i_start = 1'b0;
    repeat (2) @(negedge clk);
    check_int("wide_trig_k3", int'(o_trigger), 1);
    @(negedge clk);
    force dut.timer_q = 33'h0_FFFF_FFFE;
    @(negedge clk);
    check_int("wide_no_done_k5", int'(o_done), 0);
    check_int("wide_busy_k5", int'(o_busy), 1);
    force dut.timer_q = 33'h0_FFFF_FFFF;
    @(negedge clk);
    release dut.timer_q;
    check_int("wide_no_done_k6", int'(o_done), 0);
    @(negedge clk);
    check_int("wide_done_k7", int'(o_done), 1);
    check_int("wide_stop_k7", int'(o_stop), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cfg_guard();
    int err_cnt = 0;
    wr(0, 'h5555, 0, 1, 1, 1);
    start_seq(0, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) i_start = 1'b0;
      if (o_cfg_err) err_cnt++;
      if (k == 5) check_int("guard_err_k5", int'(o_cfg_err), 1);
      if (k == 6) check_int("guard_err_k6", int'(o_cfg_err), 0);
      if (k == 5) cfg_we = 1'b0;
      if (k == 4) begin
        cfg_addr = '0; cfg_amp = 16'hBEEF; cfg_we = 1'b1;
      end
    end
    check_int("guard_err_cnt", err_cnt, 1);
    check_int("guard_amp_kept", int'(o_valid_amp), 'h5555);
    i_abort = 1'b1;
    repeat (3) @(negedge clk);
    i_abort = 1'b0;
    check_int("guard_idle_after_abort", int'(o_busy), 0);
  endtask

  task automatic test_reset_mid_run();
    wr(0, 'h6666, 'h0101, 3, 3, 2);
    start_seq(0, 1'b0);
    repeat (5) @(negedge clk);
    i_start = 1'b0;
    #2 rst = 1'b0;
    #1;
    total++;
    if ({o_valid_amp, o_zero_amp, o_data_duration, o_zero_duration, o_trigger, o_stop,
         o_busy, o_seg_idx, o_done, o_cfg_err} !== '0) $display("FAIL midrun_reset_outputs: not all zero");
    else pass_cnt++;
    check_int("midrun_state_idle", int'(dut.state_q), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start_seq(0, 1'b0);
    capture(20, 0);
    check_int("replay_amp_k2", amp_k[1], 'h6666);
    check_int("replay_zamp", int'(o_zero_amp), 'h0101);
    check_int("replay_data_dur", int'(o_data_duration), 3);
    check_trigs("replay", '{3, 9});
    check_int("replay_done_k", done_k, 15);
  endtask

  initial begin
    test_reset();
    test_idle_abort();
    test_single();
    test_repeats();
    test_loop_abort();
    test_zero_period();
    test_wide_period();
    test_cfg_guard();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
